// File: rtl/keypad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keypad_scanner                                                           |
// | Scans a 4x3 membrane keypad, debounces it and emits key codes and the    |
// | '*'/'#' button pulses. KEYPAD_FUNC_KEYS_EN enables the button pulses.     |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module keypad_scanner #(
    parameter int SCAN_DWELL      = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [2:0] col_n,
    output logic [3:0] key,
    output logic       time_button,
    output logic       alarm_button
);

    localparam int c_DWELL_W = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
    localparam int c_CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(SCAN_DWELL - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST   = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]           c_NO_KEY     = 4'hA;

    typedef enum logic [1:0] {
        ST_SCAN       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_RELEASE_DB = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [3:0]           r_sync1, r_rows;
    logic [c_DWELL_W-1:0] r_dwell, w_dwell_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [1:0]           r_col, w_col_nxt, w_col_inc;
    logic [2:0]           r_col_n;
    logic [3:0]           r_pat, w_pat_nxt;
    logic [1:0]           r_row, w_row_nxt, w_row_idx;
    logic [3:0]           r_key, w_key_nxt;
    logic                 r_time, w_time_nxt;
    logic                 r_alarm, w_alarm_nxt;
    logic [3:0]           w_rows_eff, w_low;
    logic                 w_single_low, w_func_key;

    function automatic logic [3:0] f_key_code(input logic [1:0] row, input logic [1:0] col);
        if (row == 2'd3) return 4'd0;
        return ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 4'hF;
            r_rows  <= 4'hF;
        end else begin
            r_sync1 <= row_n;
            r_rows  <= r_sync1;
        end
    end

`ifdef KEYPAD_FUNC_KEYS_EN
    assign w_rows_eff = r_rows;
`else
    // Without function keys, '*' and '#' are invisible to the scanner.
    assign w_rows_eff = (r_col == 2'd1) ? r_rows : (r_rows | 4'b1000);
`endif

    assign w_low        = ~w_rows_eff;
    assign w_single_low = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);
    assign w_col_inc    = (r_col == 2'd2) ? 2'd0 : r_col + 2'd1;
    assign w_func_key   = (r_row == 2'd3) && (r_col != 2'd1);

    always_comb begin
        w_row_idx = 2'd0;
        case (w_low)
            4'b0010: w_row_idx = 2'd1;
            4'b0100: w_row_idx = 2'd2;
            4'b1000: w_row_idx = 2'd3;
            default: w_row_idx = 2'd0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dwell_nxt = r_dwell;
        w_cnt_nxt   = r_cnt;
        w_col_nxt   = r_col;
        w_pat_nxt   = r_pat;
        w_row_nxt   = r_row;
        w_key_nxt   = r_key;
        w_time_nxt  = 1'b0;
        w_alarm_nxt = 1'b0;
        case (r_state)
            ST_SCAN: begin
                if (r_dwell == c_DWELL_LAST) begin
                    w_dwell_nxt = '0;
                    if (w_single_low) begin
                        w_pat_nxt   = w_rows_eff;
                        w_row_nxt   = w_row_idx;
                        w_cnt_nxt   = c_CNT_W'(1);
                        w_state_nxt = ST_PRESS_DB;
                    end else begin
                        w_col_nxt = w_col_inc;
                    end
                end else begin
                    w_dwell_nxt = r_dwell + 1'b1;
                end
            end
            ST_PRESS_DB: begin
                if (w_rows_eff != r_pat) begin
                    w_cnt_nxt   = '0;
                    w_col_nxt   = w_col_inc;
                    w_state_nxt = ST_SCAN;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_PRESSED;
                    if (w_func_key) begin
`ifdef KEYPAD_FUNC_KEYS_EN
                        w_time_nxt  = (r_col == 2'd0);
                        w_alarm_nxt = (r_col == 2'd2);
`endif
                    end else begin
                        w_key_nxt = f_key_code(r_row, r_col);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (r_rows[r_row]) begin
                    w_cnt_nxt   = c_CNT_W'(1);
                    w_state_nxt = ST_RELEASE_DB;
                end
            end
            ST_RELEASE_DB: begin
                if (!r_rows[r_row]) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_PRESSED;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_key_nxt   = c_NO_KEY;
                    w_col_nxt   = w_col_inc;
                    w_state_nxt = ST_SCAN;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_SCAN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_SCAN;
            r_dwell <= '0;
            r_cnt   <= '0;
            r_col   <= 2'd0;
            r_col_n <= 3'b110;
            r_pat   <= 4'hF;
            r_row   <= 2'd0;
            r_key   <= c_NO_KEY;
            r_time  <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dwell <= w_dwell_nxt;
            r_cnt   <= w_cnt_nxt;
            r_col   <= w_col_nxt;
            r_col_n <= ~(3'b001 << w_col_nxt);
            r_pat   <= w_pat_nxt;
            r_row   <= w_row_nxt;
            r_key   <= w_key_nxt;
            r_time  <= w_time_nxt;
            r_alarm <= w_alarm_nxt;
        end
    end

    assign col_n        = r_col_n;
    assign key          = r_key;
    assign time_button  = r_time;
    assign alarm_button = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_keypad_scanner                                                        |
// | Directed, self-checking bench for keypad_scanner with a keypad model.    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_keypad_scanner;

    logic       clock;
    logic       reset;
    logic [3:0] row_n;
    logic [2:0] col_n;
    logic [3:0] key;
    logic       time_button;
    logic       alarm_button;

    logic [2:0] kd [4];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int r;
        int c;
        int exp_key;
        int exp_tb;
        int exp_ab;
    } vec_t;

    vec_t vecs [12];

    logic mon_en = 1'b0;
    int   mon_vals [$];
    int   mon_lens [$];
    int   mon_tb = 0;
    int   mon_ab = 0;

    keypad_scanner dut (
        .clock        (clock),
        .reset        (reset),
        .row_n        (row_n),
        .col_n        (col_n),
        .key          (key),
        .time_button  (time_button),
        .alarm_button (alarm_button)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // A pressed key shorts its row to its column only while that column is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) row_n[r] = ~|(kd[r] & ~col_n);
    end

    always @(negedge clock) begin
        if (mon_en) begin
            if (mon_vals.size() == 0 || mon_vals[mon_vals.size()-1] != int'(key)) begin
                mon_vals.push_back(int'(key));
                mon_lens.push_back(1);
            end else begin
                mon_lens[mon_lens.size()-1] = mon_lens[mon_lens.size()-1] + 1;
            end
            if (time_button)  mon_tb++;
            if (alarm_button) mon_ab++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tap(input int r, input int c, input int hold, input int gap);
        @(negedge clock);
        kd[r][c] = 1'b1;
        repeat (hold) @(negedge clock);
        kd[r][c] = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    int       n;
    int       errs;
    int       rises;
    logic     found;
    int       gk, gt, ga;
    logic [2:0] prev_col;
    int       col_changes;

    initial begin
        vecs[0]  = '{0, 0, 1, 0, 0};
        vecs[1]  = '{0, 1, 2, 0, 0};
        vecs[2]  = '{0, 2, 3, 0, 0};
        vecs[3]  = '{1, 0, 4, 0, 0};
        vecs[4]  = '{1, 1, 5, 0, 0};
        vecs[5]  = '{1, 2, 6, 0, 0};
        vecs[6]  = '{2, 0, 7, 0, 0};
        vecs[7]  = '{2, 1, 8, 0, 0};
        vecs[8]  = '{2, 2, 9, 0, 0};
        vecs[10] = '{3, 1, 0, 0, 0};
`ifdef KEYPAD_FUNC_KEYS_EN
        vecs[9]  = '{3, 0, 10, 1, 0};
        vecs[11] = '{3, 2, 10, 0, 1};
`else
        vecs[9]  = '{3, 0, 10, 0, 0};
        vecs[11] = '{3, 2, 10, 0, 0};
`endif
        for (int r = 0; r < 4; r++) kd[r] = 3'b000;

        // Reset values, applied asynchronously
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("reset_key", int'(key), 10);
        chk("reset_col_n", int'(col_n), 3'b110);
        chk("reset_time_button", int'(time_button), 0);
        chk("reset_alarm_button", int'(alarm_button), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);

        // Table: every key of the pad
        for (int v = 0; v < 12; v++) begin
            @(negedge clock);
            kd[vecs[v].r][vecs[v].c] = 1'b1;
            found = 1'b0; gk = 10; gt = 0; ga = 0;
            for (int i = 0; i < 40 && !found; i++) begin
                @(negedge clock);
                if (key != 4'hA || time_button || alarm_button) begin
                    found = 1'b1;
                    gk = int'(key); gt = int'(time_button); ga = int'(alarm_button);
                end
            end
            chk($sformatf("vec%0d_key", v), gk, vecs[v].exp_key);
            chk($sformatf("vec%0d_time_button", v), gt, vecs[v].exp_tb);
            chk($sformatf("vec%0d_alarm_button", v), ga, vecs[v].exp_ab);
            if (found) begin
                @(negedge clock);
                chk($sformatf("vec%0d_key_next", v), int'(key), vecs[v].exp_key);
                chk($sformatf("vec%0d_pulse_width", v), int'(time_button | alarm_button), 0);
            end
            kd[vecs[v].r][vecs[v].c] = 1'b0;
            for (int i = 0; i < 10 && key != 4'hA; i++) @(negedge clock);
            chk($sformatf("vec%0d_release", v), int'(key), 10);
            repeat (6) @(negedge clock);
        end

        // Clean press of 5: latency, hold, exact release latency
        @(negedge clock);
        kd[1][1] = 1'b1;
        n = 0;
        while (key == 4'hA && n < 40) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (!(n >= 6 && n <= 17)) begin
            bad++;
            $display("FAIL press5_latency: got %0d cycles, expected 6..17", n);
        end
        chk("press5_key", int'(key), 5);
        errs = 0;
        repeat (30) begin
            @(negedge clock);
            if (key != 4'd5) errs++;
        end
        chk("press5_hold_glitches", errs, 0);
        kd[1][1] = 1'b0;
        n = 0;
        while (key != 4'hA && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("press5_release_latency", n, 6);
        repeat (8) @(negedge clock);

        // Bouncing press and release of 3
        errs = 0; rises = 0;
        for (int i = 0; i < 12; i++) begin
            kd[0][2] = ((i / 2) % 2 == 0);
            @(negedge clock);
            if (key != 4'hA) errs++;
        end
        kd[0][2] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (key != 4'hA && key != 4'd3) errs++;
            if (key == 4'd3 && i > 0 && rises == 0) rises++;
        end
        chk("bounce_press_bad_values", errs, 0);
        chk("bounce_press_key", int'(key), 3);
        errs = 0;
        for (int i = 0; i < 12; i++) begin
            kd[0][2] = ((i / 2) % 2 == 1);
            @(negedge clock);
            if (key != 4'd3) errs++;
        end
        chk("bounce_release_held", errs, 0);
        kd[0][2] = 1'b0;
        n = 0;
        while (key != 4'hA && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("bounce_release_latency", n, 6);
        repeat (8) @(negedge clock);

        // Ghost press: two rows on one column
        kd[0][0] = 1'b1;
        kd[2][0] = 1'b1;
        errs = 0; col_changes = 0;
        @(negedge clock);
        prev_col = col_n;
        repeat (40) begin
            @(negedge clock);
            if (key != 4'hA) errs++;
            if (col_n != prev_col) begin
                col_changes++;
                if (col_n != {prev_col[1:0], prev_col[2]}) errs++;
                prev_col = col_n;
            end
        end
        chk("ghost_errors", errs, 0);
        chk("ghost_scan_moves", int'(col_changes >= 9), 1);
        kd[0][0] = 1'b0;
        kd[2][0] = 1'b0;
        repeat (8) @(negedge clock);

        // Asynchronous reset while 7 is held
        kd[2][0] = 1'b1;
        n = 0;
        while (key != 4'd7 && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("pre_reset_key7", int'(key), 7);
        #2 reset = 1'b0;
        #1;
        chk("midpress_reset_key", int'(key), 10);
        chk("midpress_reset_col_n", int'(col_n), 3'b110);
        kd[2][0] = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("restart_col0_held", int'(col_n), 3'b110);
        @(negedge clock);
        chk("restart_col1", int'(col_n), 3'b101);
        repeat (8) @(negedge clock);

        // Clock-set sequence 1,1,2,3,*
        mon_en = 1'b1;
        tap(0, 0, 24, 14);
        tap(0, 0, 24, 14);
        tap(0, 1, 24, 14);
        tap(0, 2, 24, 14);
        tap(3, 0, 24, 14);
        mon_en = 1'b0;
        chk("seq_len", mon_vals.size(), 9);
        if (mon_vals.size() == 9) begin
            chk("seq_v0", mon_vals[0], 10);
            chk("seq_v1", mon_vals[1], 1);
            chk("seq_v2", mon_vals[2], 10);
            chk("seq_v3", mon_vals[3], 1);
            chk("seq_v4", mon_vals[4], 10);
            chk("seq_v5", mon_vals[5], 2);
            chk("seq_v6", mon_vals[6], 10);
            chk("seq_v7", mon_vals[7], 3);
            chk("seq_v8", mon_vals[8], 10);
            errs = 0;
            for (int i = 1; i < 8; i++) begin
                if (i % 2 == 1 && mon_lens[i] < 2) errs++;
                if (i % 2 == 0 && mon_lens[i] < 1) errs++;
            end
            chk("seq_run_lengths", errs, 0);
        end
`ifdef KEYPAD_FUNC_KEYS_EN
        chk("seq_time_pulses", mon_tb, 1);
`else
        chk("seq_time_pulses", mon_tb, 0);
`endif
        chk("seq_alarm_pulses", mon_ab, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
